aes_dec_controller: RTL and testbench
=====================================

Name: aes_dec_controller

Overview:
- Moore FSM that sequences the AES-128 decryption datapath behind the Avalon AES register interface.
- Takes the START bit from register 14 and returns the DONE bit for register 15.
- Drives load enables, operation select, round-key index and InvMixColumns word select to the datapath.
- Does not itself hold key, message or state words.

Parameters:
KEYEXP_CYCLES, 12, cycles to wait after KEY_START for key-schedule completion; legal range 1..255

Ports:
CLK  input  1  system clock
RESET  input  1  synchronous active-high reset
AES_START  input  1  start request (bit 0 of Start register)
AES_DONE  output  1  decryption complete (to bit 0 of Done register)
KEY_START  output  1  one-cycle pulse launching key expansion
LD_STATE  output  1  load enable for 128-bit state register
OP_SEL  output  3  datapath op select (aes_ctrl_pkg::op_t)
ROUND_IDX  output  4  round-key index, 0..10
WORD_SEL  output  2  32-bit column selected for InvMixColumns

Behaviour:
- Interface: one clock, CLK; reset is synchronous and active-high, named RESET.
- All outputs decode from state/counters only (Moore); no input-to-output combinational path.
- Reset values:
  - state IDLE
  - AES_DONE=0, KEY_START=0, LD_STATE=0
  - OP_SEL=OP_NONE, ROUND_IDX=0, WORD_SEL=0
- RESET asserted mid-run: forces IDLE at the next edge, from any state.
- States and transitions:
  - IDLE: all outputs at reset values. AES_START=1 at an edge -> LOAD.
  - LOAD (1 cycle): OP_SEL=OP_LOAD, LD_STATE=1, KEY_START=1. Ciphertext enters the state register. -> KEYWAIT.
  - KEYWAIT (KEYEXP_CYCLES cycles): down-counter, all enables 0. -> ARK_INIT when the count expires.
  - ARK_INIT (1): OP_ARK, ROUND_IDX=10, LD_STATE=1. Round counter r:=9. -> ISR.
  - ISR (1): OP_ISR, LD_STATE=1. -> ISB.
  - ISB (1): OP_ISB, LD_STATE=1. -> ARK.
  - ARK (1): OP_ARK, ROUND_IDX=r, LD_STATE=1.
    - r!=0 -> IMC with WORD_SEL=0.
    - r==0 -> DONE.
  - IMC (4 cycles): OP_IMC, LD_STATE=1, WORD_SEL 0,1,2,3; only the selected column is written. After WORD_SEL=3: r:=r-1, -> ISR.
  - DONE: AES_DONE=1, LD_STATE=0, state register holds the plaintext.
    - Stays while AES_START=1.
    - AES_START=0 -> IDLE.
- ROUND_IDX in non-ARK states: shows current r during the round loop, 0 otherwise.
- Latency: the edge sampling AES_START=1 in IDLE is edge 0. AES_DONE is first high after edge KEYEXP_CYCLES+68, i.e. edge 80 at default.
  - Breakdown: LOAD 1 + KEYWAIT K + ARK_INIT 1 + 9 rounds x 7 + final round 3.
- Op counts per run: ARK 11, ISR 10, ISB 10, IMC 36 (9 rounds x 4 words), LOAD 1.
- AES_START deasserted before DONE: ignored; the run completes, then DONE exits to IDLE on the next edge.
- AES_START held high through DONE: no retrigger. A new run requires AES_START=0 (IDLE), then 1.
- Counter widths: r is 4-bit and never wraps below 0. The KEYWAIT counter is 8-bit, loaded with KEYEXP_CYCLES-1.

Optional Feature:
- Macro AES_CTRL_PERF_EN.
- Defined:
  - Adds output CYCLE_COUNT [15:0], reset 0.
  - Clears to 0 on entry to LOAD and increments each cycle outside IDLE/DONE.
  - Saturates at 16'hFFFF and holds through DONE and IDLE until the next LOAD.
  - Equals KEYEXP_CYCLES+68 after a clean run.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package aes_ctrl_pkg:
  - op_t enum: OP_NONE=0, OP_LOAD=1, OP_ARK=2, OP_ISR=3, OP_ISB=4, OP_IMC=5.
  - state_t enum.
  - Constants NUM_ROUNDS=10 and IMC_WORDS=4.
- Sub-module aes_round_counter: 4-bit loadable down-counter with zero flag, used for r. The KEYWAIT counter reuses it via an 8-bit parameterised width.

Test Plan:
1. Reset: assert RESET 3 cycles from an arbitrary state -> all outputs 0 and OP_SEL=OP_NONE on the cycle after the first reset edge.
2. Single run, K=12: pulse AES_START high and keep it high.
   - AES_DONE rises exactly after edge 80.
   - Logged counts: ARK=11, ISR=10, ISB=10, IMC=36, LD_STATE high 68 cycles.
   - ROUND_IDX at ARK cycles is 10,9,...,0.
3. Handshake: hold AES_START through DONE for 20 cycles -> AES_DONE stays 1 and KEY_START does not re-pulse. Drop AES_START -> IDLE next cycle. Raise again -> new LOAD with KEY_START=1.
4. Short start: AES_START high 1 cycle only -> full 80-cycle run, DONE for exactly 1 cycle, then IDLE.
5. Mid-run reset: RESET at edge 40 (inside round loop) -> IDLE and reset outputs next cycle. A subsequent start yields a full 80-cycle run.
6. Perf macro (AES_CTRL_PERF_EN, KEYEXP_CYCLES=1): CYCLE_COUNT=69 in DONE; it holds 69 in IDLE and clears on the next LOAD.

Source files
------------

// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES-128 decryption controller.
// Optional build macro used by the controller: AES_CTRL_PERF_EN.
package aes_ctrl_pkg;

  localparam int unsigned NUM_ROUNDS = 10;
  localparam int unsigned IMC_WORDS  = 4;

  localparam int unsigned OP_W    = 3;
  localparam int unsigned ROUND_W = 4;
  localparam int unsigned WORD_W  = 2;
  localparam int unsigned KW_W    = 8;
  localparam int unsigned PERF_W  = 16;

  // Index of the last InvMixColumns column in a round
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(IMC_WORDS - 1);

  // Datapath operation select
  typedef enum logic [OP_W-1:0] {
    OP_NONE = 3'd0,
    OP_LOAD = 3'd1,
    OP_ARK  = 3'd2,
    OP_ISR  = 3'd3,
    OP_ISB  = 3'd4,
    OP_IMC  = 3'd5
  } op_t;

  // Controller sequencing states
  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_LOAD     = 4'd1,
    S_KEYWAIT  = 4'd2,
    S_ARK_INIT = 4'd3,
    S_ISR      = 4'd4,
    S_ISB      = 4'd5,
    S_ARK      = 4'd6,
    S_IMC      = 4'd7,
    S_DONE     = 4'd8
  } state_t;

endpackage

// File: rtl/aes_round_counter.sv
// Loadable down-counter with zero flag; never decrements below zero.
module aes_round_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero_c
);

  assign zero_c = (count == '0);

  // Load has priority over decrement; decrement saturates at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !zero_c) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/aes_dec_controller.sv
// Moore sequencer for the AES-128 decryption datapath.
// Define AES_CTRL_PERF_EN to add the CYCLE_COUNT run-length counter.
module aes_dec_controller
  import aes_ctrl_pkg::*;
#(
  parameter int unsigned KEYEXP_CYCLES = 12
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               AES_START,
  output logic               AES_DONE,
  output logic               KEY_START,
  output logic               LD_STATE,
  output logic [OP_W-1:0]    OP_SEL,
  output logic [ROUND_W-1:0] ROUND_IDX,
  output logic [WORD_W-1:0]  WORD_SEL
`ifdef AES_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0]  CYCLE_COUNT
`endif
);

  state_t state;
  state_t state_nxt;

  logic [KW_W-1:0]    kw_count;
  logic               kw_zero_c;
  logic               kw_load_c;
  logic               kw_dec_c;
  logic [ROUND_W-1:0] rnd_count;
  logic               rnd_zero_c;
  logic               rnd_load_c;
  logic               rnd_dec_c;
  logic               imc_last_c;

  // Counter controls decoded from the current state
  assign imc_last_c = (WORD_SEL == LAST_WORD);
  assign kw_load_c  = (state == S_LOAD);
  assign kw_dec_c   = (state == S_KEYWAIT) && (kw_count != '0);
  assign rnd_load_c = (state == S_KEYWAIT) && kw_zero_c;
  assign rnd_dec_c  = (state == S_IMC) && imc_last_c;

  // Key-schedule wait counter, K cycles in KEYWAIT
  aes_round_counter #(
    .W (KW_W)
  ) u_kw_cnt (
    .clk      (CLK),
    .rst      (RESET),
    .load     (kw_load_c),
    .load_val (KW_W'(KEYEXP_CYCLES - 1)),
    .dec      (kw_dec_c),
    .count    (kw_count),
    .zero_c   (kw_zero_c)
  );

  // Round counter r, loaded with 9 on entry to ARK_INIT
  aes_round_counter #(
    .W (ROUND_W)
  ) u_rnd_cnt (
    .clk      (CLK),
    .rst      (RESET),
    .load     (rnd_load_c),
    .load_val (ROUND_W'(NUM_ROUNDS - 1)),
    .dec      (rnd_dec_c),
    .count    (rnd_count),
    .zero_c   (rnd_zero_c)
  );

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (AES_START) state_nxt = S_LOAD;
      S_LOAD:     state_nxt = S_KEYWAIT;
      S_KEYWAIT:  if (kw_zero_c) state_nxt = S_ARK_INIT;
      S_ARK_INIT: state_nxt = S_ISR;
      S_ISR:      state_nxt = S_ISB;
      S_ISB:      state_nxt = S_ARK;
      S_ARK:      state_nxt = rnd_zero_c ? S_DONE : S_IMC;
      S_IMC:      if (imc_last_c) state_nxt = S_ISR;
      S_DONE:     if (!AES_START) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // State register with outputs registered from the state being entered
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= S_IDLE;
      AES_DONE  <= 1'b0;
      KEY_START <= 1'b0;
      LD_STATE  <= 1'b0;
      OP_SEL    <= OP_NONE;
      ROUND_IDX <= '0;
      WORD_SEL  <= '0;
    end else begin
      state     <= state_nxt;
      AES_DONE  <= 1'b0;
      KEY_START <= 1'b0;
      LD_STATE  <= 1'b0;
      OP_SEL    <= OP_NONE;
      ROUND_IDX <= '0;
      WORD_SEL  <= '0;
      case (state_nxt)
        S_LOAD: begin
          OP_SEL    <= OP_LOAD;
          LD_STATE  <= 1'b1;
          KEY_START <= 1'b1;
        end
        S_ARK_INIT: begin
          OP_SEL    <= OP_ARK;
          LD_STATE  <= 1'b1;
          ROUND_IDX <= ROUND_W'(NUM_ROUNDS);
        end
        S_ISR: begin
          OP_SEL    <= OP_ISR;
          LD_STATE  <= 1'b1;
          // r decrements on the same edge that leaves IMC
          ROUND_IDX <= (state == S_IMC) ? rnd_count - ROUND_W'(1) : rnd_count;
        end
        S_ISB: begin
          OP_SEL    <= OP_ISB;
          LD_STATE  <= 1'b1;
          ROUND_IDX <= rnd_count;
        end
        S_ARK: begin
          OP_SEL    <= OP_ARK;
          LD_STATE  <= 1'b1;
          ROUND_IDX <= rnd_count;
        end
        S_IMC: begin
          OP_SEL    <= OP_IMC;
          LD_STATE  <= 1'b1;
          ROUND_IDX <= rnd_count;
          WORD_SEL  <= (state == S_IMC) ? WORD_SEL + WORD_W'(1) : '0;
        end
        S_DONE: begin
          AES_DONE  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef AES_CTRL_PERF_EN
  // Run-length counter: clears entering LOAD, counts busy cycles, saturates
  always_ff @(posedge CLK) begin
    if (RESET) begin
      CYCLE_COUNT <= '0;
    end else if (state_nxt == S_LOAD) begin
      CYCLE_COUNT <= '0;
    end else if ((state != S_IDLE) && (state != S_DONE) && (CYCLE_COUNT != '1)) begin
      CYCLE_COUNT <= CYCLE_COUNT + PERF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_aes_dec_controller.sv
// Directed self-checking bench for aes_dec_controller.
// Builds with AES_CTRL_PERF_EN also exercise CYCLE_COUNT (with KEYEXP_CYCLES=1).
module tb_aes_dec_controller;
  import aes_ctrl_pkg::*;

`ifdef AES_CTRL_PERF_EN
  localparam int unsigned K = 1;
`else
  localparam int unsigned K = 12;
`endif
  localparam int RUN_BUDGET = 400;
  localparam int DONE_EDGE  = int'(K) + 68;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       AES_START = 1'b0;
  logic       AES_DONE;
  logic       KEY_START;
  logic       LD_STATE;
  logic [2:0] OP_SEL;
  logic [3:0] ROUND_IDX;
  logic [1:0] WORD_SEL;
`ifdef AES_CTRL_PERF_EN
  logic [15:0] CYCLE_COUNT;
`endif

  aes_dec_controller #(
    .KEYEXP_CYCLES (K)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .AES_START (AES_START),
    .AES_DONE  (AES_DONE),
    .KEY_START (KEY_START),
    .LD_STATE  (LD_STATE),
    .OP_SEL    (OP_SEL),
    .ROUND_IDX (ROUND_IDX),
    .WORD_SEL  (WORD_SEL)
`ifdef AES_CTRL_PERF_EN
    ,
    .CYCLE_COUNT (CYCLE_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  int n_ark, n_isr, n_isb, n_imc, n_ld, n_load, n_ks, n_wait;
  int ark_bad, isr_bad, imc_bad;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".done"},  32'(AES_DONE),  32'd0);
    check({tag, ".kst"},   32'(KEY_START), 32'd0);
    check({tag, ".ld"},    32'(LD_STATE),  32'd0);
    check({tag, ".op"},    32'(OP_SEL),    32'(OP_NONE));
    check({tag, ".round"}, 32'(ROUND_IDX), 32'd0);
    check({tag, ".word"},  32'(WORD_SEL),  32'd0);
`ifdef AES_CTRL_PERF_EN
    check({tag, ".cycles"}, 32'(CYCLE_COUNT), 32'd0);
`endif
  endtask

  // Starts a run from IDLE (called at a negedge) and logs every cycle until DONE
  task automatic run_log(input logic hold, output int done_edge);
    n_ark = 0; n_isr = 0; n_isb = 0; n_imc = 0; n_ld = 0; n_load = 0;
    n_ks = 0; n_wait = 0; ark_bad = 0; isr_bad = 0; imc_bad = 0;
    done_edge = -1;
    AES_START = 1'b1;
    @(posedge CLK);
    for (int e = 0; e < RUN_BUDGET; e++) begin
      @(negedge CLK);
      if (!hold) AES_START = 1'b0;
      if (AES_DONE) begin
        done_edge = e;
        break;
      end
      if (LD_STATE) n_ld++;
      if (KEY_START) n_ks++;
      if (OP_SEL != 3'(OP_IMC) && WORD_SEL != 2'd0) imc_bad++;
      case (OP_SEL)
        3'(OP_LOAD): n_load++;
        3'(OP_NONE): n_wait++;
        3'(OP_ARK): begin
          if (ROUND_IDX != 4'(10 - n_ark)) ark_bad++;
          n_ark++;
        end
        3'(OP_ISR): begin
          if (ROUND_IDX != 4'(9 - n_isr)) isr_bad++;
          n_isr++;
        end
        3'(OP_ISB): begin
          if (ROUND_IDX != 4'(9 - n_isb)) isr_bad++;
          n_isb++;
        end
        3'(OP_IMC): begin
          if (WORD_SEL != 2'(n_imc % 4) || ROUND_IDX != 4'(9 - n_imc / 4)) imc_bad++;
          n_imc++;
        end
        default: imc_bad++;
      endcase
    end
    if (done_edge < 0) check("run_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_run(input string tag, input int done_edge);
    check({tag, ".done_edge"}, 32'(done_edge), 32'(DONE_EDGE));
    check({tag, ".n_ark"},  32'(n_ark),  32'd11);
    check({tag, ".n_isr"},  32'(n_isr),  32'd10);
    check({tag, ".n_isb"},  32'(n_isb),  32'd10);
    check({tag, ".n_imc"},  32'(n_imc),  32'd36);
    check({tag, ".n_ld"},   32'(n_ld),   32'd68);
    check({tag, ".n_load"}, 32'(n_load), 32'd1);
    check({tag, ".n_ks"},   32'(n_ks),   32'd1);
    check({tag, ".n_wait"}, 32'(n_wait), 32'(K));
    check({tag, ".ark_idx"}, 32'(ark_bad), 32'd0);
    check({tag, ".isr_idx"}, 32'(isr_bad), 32'd0);
    check({tag, ".imc_seq"}, 32'(imc_bad), 32'd0);
  endtask

  initial begin
    int de;
    int dn;
    int ks;

    // Power-on reset
    RESET = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    check_idle("por");

    // Reset from an arbitrary mid-run state, held three cycles
    AES_START = 1'b1;
    repeat (20) @(negedge CLK);
    AES_START = 1'b0;
    RESET = 1'b1;
    @(negedge CLK);
    check_idle("rst");
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);

    // Single run with AES_START held high
    run_log(1'b1, de);
    check_run("run1", de);
`ifdef AES_CTRL_PERF_EN
    check("perf_done", 32'(CYCLE_COUNT), 32'(DONE_EDGE));
`endif

    // Handshake: DONE holds while start stays high, no retrigger
    dn = 0;
    ks = 0;
    repeat (20) begin
      @(negedge CLK);
      dn += int'(AES_DONE);
      ks += int'(KEY_START);
    end
    check("hs_done_held", 32'(dn), 32'd20);
    check("hs_no_kstart", 32'(ks), 32'd0);
    AES_START = 1'b0;
    @(negedge CLK);
    check("hs_idle_done", 32'(AES_DONE), 32'd0);
    check("hs_idle_op",   32'(OP_SEL),   32'(OP_NONE));
`ifdef AES_CTRL_PERF_EN
    check("perf_idle_hold", 32'(CYCLE_COUNT), 32'(DONE_EDGE));
    repeat (3) @(negedge CLK);
    check("perf_idle_hold3", 32'(CYCLE_COUNT), 32'(DONE_EDGE));
`endif
    AES_START = 1'b1;
    @(negedge CLK);
    check("hs_restart_kst", 32'(KEY_START), 32'd1);
    check("hs_restart_op",  32'(OP_SEL),    32'(OP_LOAD));
`ifdef AES_CTRL_PERF_EN
    check("perf_clear", 32'(CYCLE_COUNT), 32'd0);
`endif
    AES_START = 1'b0;
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    check_idle("hs_rst");

    // Short start: one-cycle pulse still completes, DONE lasts one cycle
    run_log(1'b0, de);
    check_run("short", de);
    @(negedge CLK);
    check("short_exit_done", 32'(AES_DONE), 32'd0);
    check("short_exit_op",   32'(OP_SEL),   32'(OP_NONE));

    // Mid-run reset sampled at edge 40, then a clean full run
    AES_START = 1'b1;
    @(negedge CLK);
    AES_START = 1'b0;
    repeat (39) @(negedge CLK);
    check("mid_busy", 32'(LD_STATE), 32'd1);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    check_idle("mid_rst");
    @(negedge CLK);
    check_idle("mid_idle");
    run_log(1'b0, de);
    check_run("after_rst", de);
    @(negedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
